// File: rtl/ifetch_unit_if.sv
// Fetch-side bundle: instruction-memory request/response, redirect and decode hand-off.
// The master modport is the fetch unit; the slave modport is its environment.
interface ifetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid_out;
    logic            imem_req_ready_in;
    logic [XLEN-1:0] imem_req_addr_out;
    logic            imem_rsp_valid_in;
    logic [31:0]     imem_rsp_data_in;
    logic            redirect_valid_in;
    logic [XLEN-1:0] redirect_pc_in;
    logic            instr_valid_out;
    logic            instr_ready_in;
    logic [31:0]     instr_out;
    logic [XLEN-1:0] instr_pc_out;

    modport master (
        output imem_req_valid_out, imem_req_addr_out,
        output instr_valid_out, instr_out, instr_pc_out,
        input  imem_req_ready_in, imem_rsp_valid_in, imem_rsp_data_in,
        input  redirect_valid_in, redirect_pc_in, instr_ready_in
    );

    modport slave (
        input  imem_req_valid_out, imem_req_addr_out,
        input  instr_valid_out, instr_out, instr_pc_out,
        output imem_req_ready_in, imem_rsp_valid_in, imem_rsp_data_in,
        output redirect_valid_in, redirect_pc_in, instr_ready_in
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited sequential fetches
// and buffers in-order responses in a small FIFO; redirects flush and discard stale fetches.
module ifetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              DEPTH    = 4
) (
    input  logic          sysclk,
    input  logic          nrst_in,
    ifetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [CW-1:0]   CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1'b1);
    localparam logic [PW-1:0]   PTR_ZERO   = {PW{1'b0}};
    localparam logic [PW-1:0]   PTR_ONE    = PW'(1'b1);
    localparam logic [CW:0]     CREDITS    = (CW+1)'(DEPTH);

    logic            run_r;
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] rsp_pc_r;
    logic [CW-1:0]   inflight_r;
    logic [CW-1:0]   discard_r;
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   head_r;
    logic [PW-1:0]   tail_r;
    logic [XLEN-1:0] pc_mem_r   [DEPTH];
    logic [31:0]     data_mem_r [DEPTH];

    logic          credit_s;
    logic          req_valid_s;
    logic          req_fire_s;
    logic          rsp_s;
    logic          push_s;
    logic          pop_s;
    logic          instr_valid_s;
    logic [CW-1:0] inflight_next_s;

    // Handshake decode; credits come from registered state only, redirect masks both valids
    always_comb begin
        credit_s        = ({1'b0, inflight_r} + {1'b0, count_r}) < CREDITS;
        req_valid_s     = run_r && credit_s && !bus.redirect_valid_in;
        req_fire_s      = req_valid_s && bus.imem_req_ready_in;
        rsp_s           = bus.imem_rsp_valid_in;
        push_s          = rsp_s && !bus.redirect_valid_in && (discard_r == CNT_ZERO);
        instr_valid_s   = (count_r != CNT_ZERO) && !bus.redirect_valid_in;
        pop_s           = instr_valid_s && bus.instr_ready_in;
        inflight_next_s = inflight_r + CW'(req_fire_s) - CW'(rsp_s);
    end

    assign bus.imem_req_valid_out = req_valid_s;
    assign bus.imem_req_addr_out  = fetch_pc_r;
    assign bus.instr_valid_out    = instr_valid_s;
    assign bus.instr_out          = data_mem_r[head_r];
    assign bus.instr_pc_out       = pc_mem_r[head_r];

    // PC, credit, discard and FIFO state
    always_ff @(posedge sysclk or negedge nrst_in) begin
        if (!nrst_in) begin
            run_r      <= 1'b0;
            fetch_pc_r <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
            inflight_r <= CNT_ZERO;
            discard_r  <= CNT_ZERO;
            count_r    <= CNT_ZERO;
            head_r     <= PTR_ZERO;
            tail_r     <= PTR_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= {XLEN{1'b0}};
                data_mem_r[i] <= 32'h0000_0000;
            end
        end else begin
            run_r      <= 1'b1;
            inflight_r <= inflight_next_s;
            if (bus.redirect_valid_in) begin
                // every fetch still outstanding after this cycle belongs to the old stream
                fetch_pc_r <= bus.redirect_pc_in & ALIGN_MASK;
                rsp_pc_r   <= bus.redirect_pc_in & ALIGN_MASK;
                discard_r  <= inflight_r - CW'(rsp_s);
                count_r    <= CNT_ZERO;
                head_r     <= PTR_ZERO;
                tail_r     <= PTR_ZERO;
            end else begin
                if (req_fire_s) begin
                    fetch_pc_r <= fetch_pc_r + PC_STEP;
                end
                if (rsp_s && (discard_r != CNT_ZERO)) begin
                    discard_r <= discard_r - CNT_ONE;
                end
                if (push_s) begin
                    pc_mem_r[tail_r]   <= rsp_pc_r;
                    data_mem_r[tail_r] <= bus.imem_rsp_data_in;
                    tail_r             <= tail_r + PTR_ONE;
                    rsp_pc_r           <= rsp_pc_r + PC_STEP;
                end
                if (pop_s) begin
                    head_r <= head_r + PTR_ONE;
                end
                count_r <= count_r + CW'(push_s) - CW'(pop_s);
            end
        end
    end

    ifetch_unit_checker #(.CW(CW), .DEPTH(DEPTH)) u_checker (
        .clk       (sysclk),
        .rst_n     (nrst_in),
        .rsp_valid (bus.imem_rsp_valid_in),
        .inflight  (inflight_r),
        .count     (count_r)
    );
endmodule

// Protocol checks on the memory response channel and buffer occupancy.
module ifetch_unit_checker #(
    parameter int CW    = 3,
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    input logic          rsp_valid,
    input logic [CW-1:0] inflight,
    input logic [CW-1:0] count
);
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |-> (inflight != {CW{1'b0}}));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |-> (count != CW'(DEPTH)));
    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (({1'b0, inflight} + {1'b0, count}) <= (CW+1)'(DEPTH)));
endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: a transaction-level memory and decode model predicts
// request valid/address, instruction valid and the delivered {pc, instr} stream.
module tb_ifetch_unit;
    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    logic clk;
    logic nrst;
    ifetch_unit_if #(.XLEN(XLEN)) bus ();

    ifetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .sysclk  (clk),
        .nrst_in (nrst),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    mreq_t       mq[$];
    logic [31:0] bufq[$];
    logic [31:0] exp_req_pc;
    int          abs_cyc   = 0;
    int          cyc_rel   = 0;
    int          last_due  = 0;
    int          p_req_rdy = 100;
    int          p_dec_rdy = 100;
    int          p_redir   = 0;
    int          lat_min   = 1;
    int          lat_max   = 1;
    bit          force_redir = 1'b0;
    logic [31:0] force_target;
    int          hs_count, acc_count, first_acc_cyc;
    logic [31:0] first_acc_pc;
    bit          combo_seen, wrap_req_seen, wrap_acc_seen;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, abs_cyc);
    endtask

    task automatic clear_stats();
        hs_count = 0; acc_count = 0; first_acc_cyc = -1; first_acc_pc = 32'h0;
        combo_seen = 1'b0; wrap_req_seen = 1'b0; wrap_acc_seen = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.imem_req_ready_in = 1'b0;
        bus.imem_rsp_valid_in = 1'b0;
        bus.imem_rsp_data_in  = 32'h0;
        bus.redirect_valid_in = 1'b0;
        bus.redirect_pc_in    = 32'h0;
        bus.instr_ready_in    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        idle_inputs();
        #1;
        check_val("rst_req_valid", bus.imem_req_valid_out, 32'd0);
        check_val("rst_instr_valid", bus.instr_valid_out, 32'd0);
        mq.delete();
        bufq.delete();
        repeat (2) @(posedge clk);
        #2 nrst = 1'b1;
        cyc_rel = 0;
        last_due = 0;
        exp_req_pc = RESET_PC;
    endtask

    // One clock: drive at negedge, check against the model, then advance the model.
    task automatic step();
        logic        redir, rsp, hs, acc;
        logic [31:0] target, a, p;
        int          lat, due;
        mreq_t       m;
        @(negedge clk);
        redir  = force_redir || ($urandom_range(99) < p_redir);
        target = force_redir ? force_target : $urandom;
        force_redir = 1'b0;
        rsp = (mq.size() > 0) && (mq[0].due <= abs_cyc);
        bus.redirect_valid_in = redir;
        bus.redirect_pc_in    = target;
        bus.imem_req_ready_in = ($urandom_range(99) < p_req_rdy);
        bus.instr_ready_in    = ($urandom_range(99) < p_dec_rdy);
        bus.imem_rsp_valid_in = rsp;
        bus.imem_rsp_data_in  = rsp ? memfn(mq[0].addr) : $urandom;
        #1;
        check_val("req_valid", bus.imem_req_valid_out,
                  (cyc_rel >= 1) && (mq.size() + bufq.size() < DEPTH) && !redir);
        check_val("instr_valid", bus.instr_valid_out, (bufq.size() > 0) && !redir);
        hs  = bus.imem_req_valid_out && bus.imem_req_ready_in;
        acc = bus.instr_valid_out && bus.instr_ready_in;
        a   = bus.imem_req_addr_out;
        if (redir && rsp && (bufq.size() > 0) && bus.instr_ready_in) combo_seen = 1'b1;
        if (hs) begin
            check_val("req_addr", a, exp_req_pc);
            hs_count++;
            if (a == 32'h0) wrap_req_seen = 1'b1;
        end
        if (acc && (bufq.size() > 0)) begin
            p = bufq.pop_front();
            check_val("instr_pc", bus.instr_pc_out, p);
            check_val("instr_data", bus.instr_out, memfn(p));
            acc_count++;
            if (first_acc_cyc < 0) begin
                first_acc_cyc = cyc_rel;
                first_acc_pc  = bus.instr_pc_out;
            end
            if (p == 32'h0) wrap_acc_seen = 1'b1;
        end
        if (rsp) begin
            m = mq.pop_front();
            if (!m.stale && !redir) bufq.push_back(m.addr);
        end
        if (redir) begin
            foreach (mq[i]) mq[i].stale = 1'b1;
            bufq.delete();
            exp_req_pc = {target[31:2], 2'b00};
        end
        if (hs) begin
            lat = $urandom_range(lat_max, lat_min);
            due = abs_cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: a, due: due, stale: 1'b0});
            exp_req_pc = exp_req_pc + 32'd4;
        end
        @(posedge clk);
        abs_cyc++;
        cyc_rel++;
    endtask

    initial begin
        nrst = 1'b0;
        idle_inputs();
        exp_req_pc = RESET_PC;

        // Sequential stream, 1-cycle memory, decode always ready
        clear_stats();
        do_reset();
        repeat (33) step();
        check_val("first_instr_cycle", first_acc_cyc, 32'd3);
        check_val("first_instr_pc", first_acc_pc, RESET_PC);
        check_val("throughput", acc_count, 32'd30);

        // Decode stalled for 20 cycles: exactly DEPTH fetches, then drain in order
        clear_stats();
        do_reset();
        p_dec_rdy = 0;
        repeat (20) step();
        check_val("stall_handshakes", hs_count, 32'd4);
        p_dec_rdy = 100;
        clear_stats();
        repeat (12) step();
        check_val("stall_drain_pc", first_acc_pc, RESET_PC);
        check_val("stall_resume", hs_count > 0, 32'd1);

        // Latency 3, redirect with two fetches in flight
        clear_stats();
        lat_min = 3; lat_max = 3;
        do_reset();
        for (int k = 0; k < 20 && mq.size() != 2; k++) step();
        force_redir = 1'b1; force_target = 32'h0000_2002;
        clear_stats();
        repeat (15) step();
        check_val("redir_first_pc", first_acc_pc, 32'h0000_2000);

        // Redirect coinciding with a response and a pop
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (10) step();
        force_redir = 1'b1; force_target = 32'h0000_3000;
        clear_stats();
        repeat (10) step();
        check_val("combo_cycle_hit", combo_seen, 32'd1);
        check_val("combo_first_pc", first_acc_pc, 32'h0000_3000);

        // Address wrap at the top of the address space
        force_redir = 1'b1; force_target = 32'hFFFF_FFF4;
        clear_stats();
        repeat (12) step();
        check_val("wrap_req", wrap_req_seen, 32'd1);
        check_val("wrap_instr", wrap_acc_seen, 32'd1);

        // Reset mid-stream with three fetches in flight
        lat_min = 4; lat_max = 4;
        do_reset();
        for (int k = 0; k < 20 && mq.size() != 3; k++) step();
        check_val("midrst_inflight", mq.size(), 32'd3);
        lat_min = 1; lat_max = 1;
        do_reset();
        clear_stats();
        repeat (10) step();
        check_val("midrst_first_pc", first_acc_pc, RESET_PC);

        // Randomized traffic: back-pressure, variable latency, random redirects
        p_req_rdy = 70; p_dec_rdy = 60; p_redir = 3;
        lat_min = 1; lat_max = 5;
        clear_stats();
        repeat (1500) step();
        check_val("random_progress", acc_count > 100, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Parametrised instruction-fetch front end for the next-generation RV32I core. It owns the program counter and issues sequential fetch requests to a variable-latency instruction memory over a valid/ready request channel. In-order responses are buffered in a DEPTH-entry FIFO that decouples fetch from decode. Branch/jump redirects flush the buffer and discard in-flight responses, so memory may take any number of cycles per fetch.

## Interface
- XLEN, 32: address/instruction width (≥32, multiple of 32).
- RESET_PC, 0: fetch address after reset (bits [1:0] must be 0).
- DEPTH, 4: FIFO entries and maximum (buffered + in-flight) fetches; power of 2, ≥2.

- sysclk  in  1  clock; all state on rising edge.
- nrst_in  in  1  reset, asynchronous, active-low.
- imem_req_valid_out  out  1  fetch request valid.
- imem_req_ready_in  in  1  memory accepts request.
- imem_req_addr_out  out  XLEN  fetch address (word-aligned).
- imem_rsp_valid_in  in  1  response valid; no back-pressure, always accepted.
- imem_rsp_data_in  in  32  instruction word.
- redirect_valid_in  in  1  control-flow change.
- redirect_pc_in  in  XLEN  new fetch address; bits [1:0] ignored.
- instr_valid_out  out  1  instruction available to decode.
- instr_ready_in  in  1  decode accepts instruction.
- instr_out  out  32  instruction word.
- instr_pc_out  out  XLEN  address of instr_out.

## Operation
- Registers: fetch_pc, rsp_pc, inflight (0..DEPTH), discard (0..DEPTH), FIFO of {pc, instr} with count.
- Reset (async, any time): fetch_pc = rsp_pc = RESET_PC; inflight, discard, FIFO count = 0; instr_valid_out = 0. imem_req_valid_out = 0 while nrst_in low.
- Request: imem_req_valid_out = (inflight + count < DEPTH) && !redirect_valid_in; imem_req_addr_out = fetch_pc. Credits use registered values only; no same-cycle credit return.
- Request handshake (valid && ready): fetch_pc += 4 (mod 2^XLEN, wraps to 0); inflight += 1.
- Response: inflight -= 1. If discard > 0: discard -= 1, word dropped. Else push {rsp_pc, data}, rsp_pc += 4 (wraps).
- Simultaneous request handshake and response: inflight unchanged.
- Output: instr_valid_out = (count > 0) && !redirect_valid_in; instr_out/instr_pc_out = FIFO head. Pop on instr_valid_out && instr_ready_in. Push and pop in same cycle legal, count unchanged.
- Redirect (priority over everything): fetch_pc = rsp_pc = redirect_pc_in & ~3; FIFO count = 0; no request issued; any response this cycle dropped; discard = inflight − imem_rsp_valid_in (all remaining in-flight fetches become stale).
- Back-to-back redirects: latest wins; discard recomputed from current inflight each time.
- FIFO cannot overflow by construction; response arriving with count = DEPTH is a protocol error (assertion in sim).
- imem_req_valid_out may drop without handshake only in a redirect cycle; memory acts solely on valid && ready.

## Timing
- First request: cycle after nrst_in rises, addr = RESET_PC.
- Response to decode: response in cycle N → instr_valid_out in N+1 (registered FIFO, no bypass).
- Memory latency ≥1 cycle after request handshake; responses strictly in request order.
- Throughput: 1 instr/cycle sustained when DEPTH ≥ memory latency + 2 and decode always ready.
- Redirect in cycle N: first request to new PC in N+1; earliest new-stream instruction in N+3 with 1-cycle memory.
- No combinational path from imem_rsp_* to outputs; redirect_valid_in combinationally masks both valid outputs.

## Test plan
- Reset, RESET_PC=0x100, 1-cycle memory, decode ready -> requests 0x100,0x104,0x108…; instr_pc_out 0x100 at cycle 3, then one instr/cycle, pc matching data.
- Decode ready low 20 cycles, DEPTH=4 -> exactly 4 handshakes then imem_req_valid_out=0; on ready, 4 instrs in order, fetching resumes.
- Memory latency 3, 2 fetches in flight, redirect to 0x2002 -> both stale responses dropped, next instr_pc_out = 0x2000, none from old stream.
- Redirect in same cycle as response and as FIFO pop -> response dropped, instr_valid_out=0 that cycle, discard = inflight−1, new stream correct.
- fetch_pc at 0xFFFFFFFC, XLEN=32 -> next request addr 0x00000000, instr_pc_out wraps equally.
- nrst_in low mid-stream with 3 in flight -> outputs 0 immediately; after release, first request at RESET_PC, no stale word delivered.
